vnu_pipe_sched: RTL and testbench
=================================

Name: vnu_pipe_sched

Overview:
Sequencing controller for the partial 3-stage IB variable-node pipeline (F0 LUT, F1 LUT, decision node). It walks the BSP schedule as iteration → layer → column chunk, and issues one chunk per cycle when message memory is ready. It drives the first-iteration channel-bypass select (v2c_src) and the per-stage valid tags that gate the c2v pipeline registers. It also handles drain, early termination and final hard-decision capture.

Parameters:
ITER_MAX, 10, maximum decoding iterations
LAYER_NUM, 4, layers per iteration
CHUNK_NUM, 9, column chunks issued per layer
ITER_W, 4, iteration counter width, must satisfy 2^ITER_W > ITER_MAX
LAYER_W, 2, layer index width
CHUNK_W, 4, chunk address width
PIPELINE_DEPTH, 3, VNU pipeline stages; valid tags track exactly this depth

Ports:
read_clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a codeword decode; ignored unless IDLE
msg_rdy  in  1  message memory can supply/accept a chunk this cycle
syndrome_ok  in  1  parity check satisfied; sampled only at iteration end
v2c_src  out  1  1 = bypass ch_llr to all v2c outputs (iteration 0)
iter_cnt  out  ITER_W  current iteration index
layer_id  out  LAYER_W  layer of the chunk issued this cycle
chunk_addr  out  CHUNK_W  chunk address of the chunk issued this cycle
issue_vld  out  1  a chunk enters stage F0 this cycle
stage_vld  out  PIPELINE_DEPTH  bit k = stage k holds a valid chunk
dec_en  out  1  write enable for the hard-decision buffer
busy  out  1  not IDLE
done  out  1  one-cycle pulse at end of decode
early_stop  out  1  qualifies done; 1 = terminated by syndrome

Behaviour:
- Reset: state=IDLE. All outputs 0, all counters 0, stage_vld=0. Reset wins over every other input in the same cycle and aborts a decode mid-flight with no done pulse.
- States: IDLE, RUN, DRAIN, CHECK, FINAL.
- IDLE→RUN on start. Counters are cleared to 0 on entry to RUN.
- RUN: issue_vld = msg_rdy (combinational from state). Each issue advances chunk_addr. On wrap CHUNK_NUM-1→0, layer_id advances. On wrap LAYER_NUM-1→0 after the last chunk, go to DRAIN. msg_rdy=0 holds all counters; stage_vld continues to shift with bubbles.
- stage_vld: registered shift. stage_vld[0] <= issue_vld; stage_vld[k] <= stage_vld[k-1]. Latency issue→stage k is k+1 cycles.
- DRAIN: wait until stage_vld == 0, then go to CHECK. Minimum DRAIN duration is PIPELINE_DEPTH cycles after the last issue.
- CHECK (1 cycle):
  - If syndrome_ok=1 or iter_cnt==ITER_MAX-1, go to FINAL, with early_stop = syndrome_ok.
  - Otherwise iter_cnt++ and go to RUN.
- v2c_src = 1 exactly while iter_cnt==0 and state ∈ {RUN, DRAIN}. Otherwise 0.
- FINAL: one extra pass with issue rules identical to RUN. dec_en = stage_vld[PIPELINE_DEPTH-1] during FINAL and its drain. When drained, assert done for 1 cycle (early_stop held with it) and return to IDLE. busy=0 in the same cycle as done.
- start while busy: ignored.
- start coincident with rst: rst wins.
- ITER_MAX=1: the CHECK after iteration 0 always goes to FINAL.
- Counters are never visible out of range. chunk_addr < CHUNK_NUM and layer_id < LAYER_NUM at all times.

Decomposition:
- Shared package/define header: state encoding (localparams IDLE..FINAL), the ITER_W/LAYER_W/CHUNK_W derivation, and the QUAN_SIZE default.
- One natural sub-module: vnu_vld_shift (PIPELINE_DEPTH-bit valid shift register with synchronous active-high reset). It is reused by the datapath-side c2v pipelines.

Test Plan:
- Reset mid-RUN (iter 2, layer 1, chunk 5), assert rst 1 cycle → next cycle state IDLE, all outputs 0, no done pulse.
- start, msg_rdy=1 constant, syndrome_ok=0, ITER_MAX=10, LAYER_NUM=4, CHUNK_NUM=9 → 36 issues per iteration, exactly 10 iterations + FINAL. done at fixed cycle count; early_stop=0; v2c_src=1 only during iter 0 RUN/DRAIN.
- Same run with syndrome_ok=1 at iteration 3's CHECK → FINAL follows, done with early_stop=1, iter_cnt=3.
- msg_rdy toggling 1,0,1,0 → counters advance only on ready cycles. stage_vld shows alternating bubbles 1,0,1 delayed 1/2/3 cycles; total issues per layer still 9.
- FINAL pass → dec_en pulses exactly 36 times, each PIPELINE_DEPTH cycles after its issue_vld.
- start asserted while busy, and start with rst high → both ignored; counters undisturbed.

Source files
------------

// File: rtl/vnu_pipe_sched_pkg.sv
// Shared definitions for the VNU pipeline scheduler: defaults, width
// derivation and the controller state encoding.
package vnu_pipe_sched_pkg;

  // Smallest width able to index n distinct values (at least 1 bit).
  function automatic int width_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int ITER_MAX_DEF       = 10;
  localparam int LAYER_NUM_DEF      = 4;
  localparam int CHUNK_NUM_DEF      = 9;
  localparam int PIPELINE_DEPTH_DEF = 3;
  localparam int QUAN_SIZE          = 4;

  // The iteration counter must hold ITER_MAX itself, hence the +1.
  localparam int ITER_W_DEF  = width_for(ITER_MAX_DEF + 1);
  localparam int LAYER_W_DEF = width_for(LAYER_NUM_DEF);
  localparam int CHUNK_W_DEF = width_for(CHUNK_NUM_DEF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    CHECK = 3'd3,
    FINAL = 3'd4
  } sched_state_t;

endpackage

// File: rtl/vnu_pipe_sched_if.sv
// Control/status bundle between the decoder top level and the scheduler.
interface vnu_pipe_sched_if #(
  parameter int ITER_W         = 4,
  parameter int LAYER_W        = 2,
  parameter int CHUNK_W        = 4,
  parameter int PIPELINE_DEPTH = 3
) ();
  logic                      start;
  logic                      msg_rdy;
  logic                      syndrome_ok;
  logic                      v2c_src;
  logic [ITER_W-1:0]         iter_cnt;
  logic [LAYER_W-1:0]        layer_id;
  logic [CHUNK_W-1:0]        chunk_addr;
  logic                      issue_vld;
  logic [PIPELINE_DEPTH-1:0] stage_vld;
  logic                      dec_en;
  logic                      busy;
  logic                      done;
  logic                      early_stop;

  // Decoder side: requests decodes and reports memory / parity status.
  modport master (
    output start, msg_rdy, syndrome_ok,
    input  v2c_src, iter_cnt, layer_id, chunk_addr, issue_vld,
           stage_vld, dec_en, busy, done, early_stop
  );

  // Scheduler side.
  modport slave (
    input  start, msg_rdy, syndrome_ok,
    output v2c_src, iter_cnt, layer_id, chunk_addr, issue_vld,
           stage_vld, dec_en, busy, done, early_stop
  );
endinterface

// File: rtl/vnu_vld_shift.sv
// Valid-tag shift register: bit k is set when pipeline stage k holds a
// valid chunk. Shared with the c2v pipelines on the datapath side.
module vnu_vld_shift #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_vld,
  output logic [DEPTH-1:0] vld
);
  logic [DEPTH-1:0] vld_reg;
  logic [DEPTH-1:0] vld_next;

  assign vld_next[0] = in_vld;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign vld_next[gi] = vld_reg[gi-1];
    end
  endgenerate

  // Advance every tag one stage per cycle; reset empties the pipeline.
  always_ff @(posedge clk) begin
    if (srst) vld_reg <= '0;
    else      vld_reg <= vld_next;
  end

  assign vld = vld_reg;
endmodule

// File: rtl/vnu_pipe_sched.sv
// BSP schedule walker for the 3-stage IB variable-node pipeline:
// iteration -> layer -> chunk, with drain, syndrome check, a final
// hard-decision pass and a done/early_stop report.
module vnu_pipe_sched
  import vnu_pipe_sched_pkg::*;
#(
  parameter int ITER_MAX       = ITER_MAX_DEF,
  parameter int LAYER_NUM      = LAYER_NUM_DEF,
  parameter int CHUNK_NUM      = CHUNK_NUM_DEF,
  parameter int ITER_W         = width_for(ITER_MAX + 1),
  parameter int LAYER_W        = width_for(LAYER_NUM),
  parameter int CHUNK_W        = width_for(CHUNK_NUM),
  parameter int PIPELINE_DEPTH = PIPELINE_DEPTH_DEF
) (
  input logic            read_clk,
  input logic            rst,
  vnu_pipe_sched_if.slave bus
);
  localparam logic [ITER_W-1:0]  ITER_LAST  = ITER_W'(ITER_MAX - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(LAYER_NUM - 1);
  localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(CHUNK_NUM - 1);

  sched_state_t        state_reg, state_next;
  logic [ITER_W-1:0]   iter_reg, iter_next;
  logic [LAYER_W-1:0]  layer_reg, layer_next;
  logic [CHUNK_W-1:0]  chunk_reg, chunk_next;
  logic                pass_done_reg, pass_done_next;  // FINAL pass fully issued
  logic                stop_reg, stop_next;            // FINAL reached by syndrome
  logic                done_reg, done_next;

  logic                issuing;
  logic                issue_vld;
  logic                pass_end;
  logic [PIPELINE_DEPTH-1:0] stage_vld;

  // The FINAL pass issues like RUN until its last chunk, then only drains.
  assign issuing   = (state_reg == RUN) || ((state_reg == FINAL) && !pass_done_reg);
  assign issue_vld = issuing && bus.msg_rdy;
  assign pass_end  = issue_vld && (chunk_reg == CHUNK_LAST) && (layer_reg == LAYER_LAST);

  vnu_vld_shift #(
    .DEPTH (PIPELINE_DEPTH)
  ) u_vld_shift (
    .clk    (read_clk),
    .srst   (rst),
    .in_vld (issue_vld),
    .vld    (stage_vld)
  );

  // Next-state and counter updates for the schedule walk.
  always_comb begin
    state_next     = state_reg;
    iter_next      = iter_reg;
    layer_next     = layer_reg;
    chunk_next     = chunk_reg;
    pass_done_next = pass_done_reg;
    stop_next      = stop_reg;
    done_next      = 1'b0;

    // Chunk/layer address advance; wraps leave both at 0 for the next pass.
    if (issue_vld) begin
      if (chunk_reg == CHUNK_LAST) begin
        chunk_next = '0;
        layer_next = (layer_reg == LAYER_LAST) ? '0 : layer_reg + LAYER_W'(1);
      end else begin
        chunk_next = chunk_reg + CHUNK_W'(1);
      end
    end

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next     = RUN;
          iter_next      = '0;
          layer_next     = '0;
          chunk_next     = '0;
          pass_done_next = 1'b0;
          stop_next      = 1'b0;
        end
      end
      RUN: begin
        if (pass_end) state_next = DRAIN;
      end
      DRAIN: begin
        if (stage_vld == '0) state_next = CHECK;
      end
      CHECK: begin
        if (bus.syndrome_ok || (iter_reg == ITER_LAST)) begin
          state_next     = FINAL;
          stop_next      = bus.syndrome_ok;
          pass_done_next = 1'b0;
        end else begin
          state_next = RUN;
          iter_next  = iter_reg + ITER_W'(1);
        end
      end
      FINAL: begin
        if (pass_end) pass_done_next = 1'b1;
        if (pass_done_reg && (stage_vld == '0)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any decode without done.
  always_ff @(posedge read_clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      iter_reg      <= '0;
      layer_reg     <= '0;
      chunk_reg     <= '0;
      pass_done_reg <= 1'b0;
      stop_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      iter_reg      <= iter_next;
      layer_reg     <= layer_next;
      chunk_reg     <= chunk_next;
      pass_done_reg <= pass_done_next;
      stop_reg      <= stop_next;
      done_reg      <= done_next;
    end
  end

  // done is registered so it lands in the first IDLE cycle (busy already 0).
  assign bus.v2c_src    = (iter_reg == '0) && ((state_reg == RUN) || (state_reg == DRAIN));
  assign bus.iter_cnt   = iter_reg;
  assign bus.layer_id   = layer_reg;
  assign bus.chunk_addr = chunk_reg;
  assign bus.issue_vld  = issue_vld;
  assign bus.stage_vld  = stage_vld;
  assign bus.dec_en     = (state_reg == FINAL) && stage_vld[PIPELINE_DEPTH-1];
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = done_reg;
  assign bus.early_stop = done_reg && stop_reg;
endmodule

// File: tb/tb_vnu_pipe_sched.sv
// Self-checking bench for vnu_pipe_sched: a schedule-level model predicts
// every output per cycle from the msg_rdy pattern and the stop iteration.
module tb_vnu_pipe_sched;
  localparam int IM   = 10;
  localparam int LN   = 4;
  localparam int CN   = 9;
  localparam int D    = 3;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vnu_pipe_sched_if #(.ITER_W(4), .LAYER_W(2), .CHUNK_W(4), .PIPELINE_DEPTH(D)) bus ();

  vnu_pipe_sched #(
    .ITER_MAX(IM), .LAYER_NUM(LN), .CHUNK_NUM(CN),
    .ITER_W(4), .LAYER_W(2), .CHUNK_W(4), .PIPELINE_DEPTH(D)
  ) dut (
    .read_clk (clk),
    .rst      (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  int rdy_a [MAXC];
  int syn_a [MAXC];
  int st_a  [MAXC];
  int e_iss [MAXC];
  int e_lay [MAXC];
  int e_chk [MAXC];
  int e_itr [MAXC];
  int e_v2c [MAXC];
  int e_busy[MAXC];
  int e_fin [MAXC];
  int e_done[MAXC];
  int e_es  [MAXC];
  int n_cyc;
  int done_at;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, exp);
    end
  endtask

  // Schedule model: each pass needs LN*CN ready cycles, then D+1 cycles of
  // drain; a one-cycle check follows every non-final pass.
  function automatic void build(input int stop_iter, input int mode);
    int c, it, idx, es;
    bit fin, stop;
    for (int i = 0; i < MAXC; i++) begin
      e_iss[i] = 0; e_lay[i] = 0; e_chk[i] = 0; e_itr[i] = 0; e_v2c[i] = 0;
      e_busy[i] = 0; e_fin[i] = 0; e_done[i] = 0; e_es[i] = 0; st_a[i] = 0;
      case (mode)
        0:       rdy_a[i] = 1;
        1:       rdy_a[i] = (i % 2 == 0) ? 1 : 0;
        default: rdy_a[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      endcase
      syn_a[i] = int'($urandom_range(0, 1));
    end
    c = 0; it = 0; fin = 1'b0; es = 0;
    while (c < MAXC - 64) begin
      idx = 0;
      while (idx < LN * CN && c < MAXC - 64) begin
        e_iss[c] = rdy_a[c]; e_lay[c] = idx / CN; e_chk[c] = idx % CN;
        e_itr[c] = it; e_v2c[c] = (it == 0 && !fin) ? 1 : 0;
        e_busy[c] = 1; e_fin[c] = fin ? 1 : 0;
        if (rdy_a[c] != 0) idx++;
        c++;
      end
      for (int k = 0; k < D + 1; k++) begin
        e_itr[c] = it; e_v2c[c] = (it == 0 && !fin) ? 1 : 0;
        e_busy[c] = 1; e_fin[c] = fin ? 1 : 0;
        c++;
      end
      if (fin) break;
      stop     = (it == stop_iter) || (it == IM - 1);
      syn_a[c] = (it == stop_iter) ? 1 : 0;
      es       = syn_a[c];
      e_itr[c] = it; e_busy[c] = 1;
      c++;
      if (stop) fin = 1'b1;
      else      it++;
    end
    done_at = c;
    e_done[c] = 1; e_es[c] = es;
    for (int k = c; k < c + 3; k++) e_itr[k] = it;
    n_cyc = c + 3;
    // Spurious start pulses while busy must be ignored.
    for (int i = 1; i < c; i++)
      if (e_busy[i] != 0 && $urandom_range(0, 7) == 0) st_a[i] = 1;
  endfunction

  function automatic int exp_stage(input int c);
    int v = 0;
    for (int k = 0; k < D; k++)
      if (c - 1 - k >= 0 && e_iss[c-1-k] != 0) v |= (1 << k);
    return v;
  endfunction

  task automatic check_idle_zero(input string tag, input int c);
    chk({tag, ".busy"},       c, 32'(bus.busy), 0);
    chk({tag, ".done"},       c, 32'(bus.done), 0);
    chk({tag, ".issue_vld"},  c, 32'(bus.issue_vld), 0);
    chk({tag, ".stage_vld"},  c, 32'(bus.stage_vld), 0);
    chk({tag, ".iter_cnt"},   c, 32'(bus.iter_cnt), 0);
    chk({tag, ".layer_id"},   c, 32'(bus.layer_id), 0);
    chk({tag, ".chunk_addr"}, c, 32'(bus.chunk_addr), 0);
    chk({tag, ".v2c_src"},    c, 32'(bus.v2c_src), 0);
    chk({tag, ".dec_en"},     c, 32'(bus.dec_en), 0);
    chk({tag, ".early_stop"}, c, 32'(bus.early_stop), 0);
  endtask

  // One decode; abort_at >= 0 asserts rst (with start) during that cycle.
  task automatic run(input int stop_iter, input int mode, input int abort_at);
    int obs_done, ndec, dec_exp;
    build(stop_iter, mode);
    obs_done = -1; ndec = 0;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < n_cyc; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bus.msg_rdy     = rdy_a[c][0];
      bus.syndrome_ok = syn_a[c][0];
      bus.start       = st_a[c][0];
      @(negedge clk);
      dec_exp = (e_fin[c] != 0 && c >= D && e_iss[c-D] != 0) ? 1 : 0;
      chk("issue_vld",  c, 32'(bus.issue_vld),  e_iss[c]);
      chk("layer_id",   c, 32'(bus.layer_id),   e_lay[c]);
      chk("chunk_addr", c, 32'(bus.chunk_addr), e_chk[c]);
      chk("iter_cnt",   c, 32'(bus.iter_cnt),   e_itr[c]);
      chk("v2c_src",    c, 32'(bus.v2c_src),    e_v2c[c]);
      chk("stage_vld",  c, 32'(bus.stage_vld),  exp_stage(c));
      chk("dec_en",     c, 32'(bus.dec_en),     dec_exp);
      chk("busy",       c, 32'(bus.busy),       e_busy[c]);
      chk("done",       c, 32'(bus.done),       e_done[c]);
      chk("early_stop", c, 32'(bus.early_stop), e_es[c]);
      if (bus.dec_en === 1'b1) ndec++;
      if (bus.done === 1'b1 && obs_done < 0) obs_done = c;
      if (c == abort_at) begin
        chk("abort.iter_cnt",   c, 32'(bus.iter_cnt), 2);
        chk("abort.layer_id",   c, 32'(bus.layer_id), 1);
        chk("abort.chunk_addr", c, 32'(bus.chunk_addr), 5);
        @(posedge clk); #1;
        rst = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check_idle_zero("after_rst", c + 2);
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          chk("after_rst.done", c + 3 + k, 32'(bus.done), 0);
          chk("after_rst.busy", c + 3 + k, 32'(bus.busy), 0);
        end
        $display("run aborted by reset at cycle %0d", c);
        return;
      end
    end
    chk("done_cycle", 0, 32'(obs_done), done_at);
    chk("dec_en_count", 0, 32'(ndec), LN * CN);
    if (mode == 0) chk("done_cycle_formula", 0, 32'(obs_done),
                       (stop_iter >= 0 && stop_iter < IM) ? 41 * (stop_iter + 1) + 40 : 41 * IM + 40);
    $display("run stop_iter=%0d mode=%0d done_at=%0d dec_en=%0d", stop_iter, mode, obs_done, ndec);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.msg_rdy = 1'b0; bus.syndrome_ok = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset", 0);
    #1 bus.msg_rdy = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    check_idle_zero("reset_with_start", 1);
    rst = 1'b0; bus.start = 1'b0;
    repeat (2) @(posedge clk);

    run(-1, 0, -1);                      // full 10 iterations, always ready
    run(3, 0, -1);                       // syndrome at iteration 3's check
    run(-1, 1, -1);                      // msg_rdy alternating 1,0,1,0
    run(int'($urandom_range(0, 12)), 2, -1);
    run(int'($urandom_range(0, 12)), 2, -1);
    run(9, 2, -1);                       // syndrome and last iteration together
    run(-1, 0, 41 * 2 + CN + 5);         // reset at iter 2, layer 1, chunk 5

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
